// File: rtl/mode_counter_pkg.sv
// Shared mode encoding and bound helpers for mode_counter.
package mode_counter_pkg;

   typedef enum logic [1:0] {
      MODE_ALL  = 2'd0,
      MODE_EVEN = 2'd1,
      MODE_ODD  = 2'd2
   } mode_t;

   // Conflicting or absent selects fall back to plain counting.
   function automatic mode_t mode_decode(input logic even, input logic odd);
      if (even && !odd)
         return MODE_EVEN;
      else if (odd && !even)
         return MODE_ODD;
      else
         return MODE_ALL;
   endfunction

   function automatic int mode_lo(input mode_t mode);
      return (mode == MODE_ODD) ? 1 : 0;
   endfunction

   function automatic int mode_hi(input mode_t mode, input int mod_max);
      case (mode)
         MODE_EVEN: return mod_max - (mod_max % 2);
         MODE_ODD:  return ((mod_max % 2) == 1) ? mod_max : mod_max - 1;
         default:   return mod_max;
      endcase
   endfunction

endpackage

// File: rtl/mode_counter_tick_prescaler.sv
// Clock-enable prescaler: step is high on every TICK_DIV-th enabled cycle.
module tick_prescaler #(
   parameter int TICK_DIV = 50000000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   output logic step
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] r_cnt;

   assign step = en && (r_cnt == LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_cnt <= '0;
      else if (!en || step)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/mode_counter.sv
// Modulus up/down counter with even/odd/all stepping, hold, load and tick prescaler.
// Define MODE_COUNTER_SATURATE_EN to clamp at the limits instead of wrapping.
module mode_counter
   import mode_counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MOD_MAX  = 15,
   parameter int TICK_DIV = 50000000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             up,
   input  logic             even,
   input  logic             odd,
   input  logic             hold,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MOD_MAX);

   logic [WIDTH-1:0]        r_count;
   logic                    r_tick;
   logic                    r_wrap;

   logic                    w_step;
   mode_t                   w_mode;
   logic [WIDTH-1:0]        w_lo;
   logic [WIDTH-1:0]        w_hi;
   logic                    w_valid;
   logic [WIDTH:0]          w_delta;
   logic [WIDTH:0]          w_up_next;
   logic signed [WIDTH:0]   w_dn_next;
   logic                    w_over;
   logic                    w_under;
   logic [WIDTH-1:0]        w_up_limit;
   logic [WIDTH-1:0]        w_dn_limit;
   logic [WIDTH-1:0]        w_next;
   logic                    w_wrap;
   logic [WIDTH-1:0]        w_load_val;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .step    (w_step)
   );

   assign w_mode = mode_decode(even, odd);
   assign w_lo   = WIDTH'(mode_lo(w_mode));
   assign w_hi   = WIDTH'(mode_hi(w_mode, MOD_MAX));

   always_comb begin
      w_valid = 1'b1;
      case (w_mode)
         MODE_EVEN: w_valid = ~r_count[0];
         MODE_ODD:  w_valid = r_count[0];
         default:   w_valid = 1'b1;
      endcase
   end

   // A misaligned count takes a single step to reach the mode's parity.
   assign w_delta   = (w_valid && (w_mode != MODE_ALL)) ? (WIDTH+1)'(2) : (WIDTH+1)'(1);
   assign w_up_next = {1'b0, r_count} + w_delta;
   assign w_dn_next = $signed({1'b0, r_count} - w_delta);
   assign w_over    = w_up_next > {1'b0, w_hi};
   assign w_under   = w_dn_next < $signed({1'b0, w_lo});

`ifdef MODE_COUNTER_SATURATE_EN
   assign w_up_limit = w_hi;
   assign w_dn_limit = w_lo;
`else
   assign w_up_limit = w_lo;
   assign w_dn_limit = w_hi;
`endif

   always_comb begin
      w_next = r_count;
      w_wrap = 1'b0;
      if (up) begin
         w_wrap = w_over;
         w_next = w_over ? w_up_limit : w_up_next[WIDTH-1:0];
      end else begin
         w_wrap = w_under;
         w_next = w_under ? w_dn_limit : w_dn_next[WIDTH-1:0];
      end
   end

   assign w_load_val = (load_val > MAX_W) ? MAX_W : load_val;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
         r_tick  <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_tick <= w_step;
         r_wrap <= 1'b0;
         if (load) begin
            r_count <= w_load_val;
         end else if (w_step && !hold) begin
            r_count <= w_next;
            r_wrap  <= w_wrap;
         end
      end
   end

   assign count = r_count;
   assign tick  = r_tick;
   assign wrap  = r_wrap;

endmodule

// File: tb/tb_mode_counter.sv
// Self-checking bench for mode_counter with a cycle-level behavioural model.
module tb_mode_counter;

   localparam int W  = 4;
   localparam int MM = 9;
   localparam int TD = 4;
`ifdef MODE_COUNTER_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         en = 1'b0;
   logic         up = 1'b0;
   logic         even = 1'b0;
   logic         odd = 1'b0;
   logic         hold = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] count;
   logic         tick;
   logic         wrap;

   int n_chk = 0;
   int n_pass = 0;
   bit chk_on = 1'b0;

   int m_count = 0;
   int m_pre = 0;
   bit m_tick = 1'b0;
   bit m_wrap = 1'b0;

   always #5 clk = ~clk;

   mode_counter #(
      .WIDTH    (W),
      .MOD_MAX  (MM),
      .TICK_DIV (TD)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (en),
      .up       (up),
      .even     (even),
      .odd      (odd),
      .hold     (hold),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .tick     (tick),
      .wrap     (wrap)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   // Model of one rising edge, from the range/parity rules in plain integers.
   task automatic model_edge();
      int lo, hi, stride, nxt;
      bit stp, aligned;
      stp = en && (m_pre == TD - 1);
      m_pre = (!en || stp) ? 0 : m_pre + 1;
      m_tick = stp;
      m_wrap = 1'b0;
      if (load) begin
         m_count = (int'(load_val) > MM) ? MM : int'(load_val);
      end else if (stp && !hold) begin
         if (even && !odd) begin
            lo = 0; hi = MM - (MM % 2); aligned = (m_count % 2 == 0); stride = 2;
         end else if (odd && !even) begin
            lo = 1; hi = (MM % 2 == 1) ? MM : MM - 1; aligned = (m_count % 2 == 1); stride = 2;
         end else begin
            lo = 0; hi = MM; aligned = 1'b1; stride = 1;
         end
         if (!aligned) stride = 1;
         nxt = up ? m_count + stride : m_count - stride;
         if (nxt > hi) begin
            m_wrap = 1'b1;
            m_count = SAT ? hi : lo;
         end else if (nxt < lo) begin
            m_wrap = 1'b1;
            m_count = SAT ? lo : hi;
         end else begin
            m_count = nxt;
         end
      end
   endtask

   always @(negedge clk) begin
      if (!reset_n) begin
         m_count = 0;
         m_pre = 0;
         m_tick = 1'b0;
         m_wrap = 1'b0;
      end else begin
         model_edge();
      end
      if (chk_on) begin
         chk("model_count", count, m_count);
         chk("model_tick", tick, m_tick);
         chk("model_wrap", wrap, m_wrap);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wait_step(input string name);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
         cyc(1);
         if (tick) got = 1'b1;
      end
      chk({name, "_tick_seen"}, got, 1);
   endtask

   int exp_c[6];
   int exp_w[6];
   int nticks;

   initial begin
      cyc(2);
      chk("rst_count", count, 0);
      chk("rst_tick", tick, 0);
      chk("rst_wrap", wrap, 0);
      reset_n = 1'b1;
      chk_on = 1'b1;

      // ALL mode up from reset
      en = 1'b1; up = 1'b1;
      cyc(3);
      chk("first_tick_early", tick, 0);
      chk("first_count_early", count, 0);
      cyc(1);
      chk("first_tick", tick, 1);
      chk("first_step", count, 1);
      cyc(32);
      chk("all_up_top", count, 9);
      chk("all_up_nowrap", wrap, 0);
      cyc(4);
      chk("all_up_wrap_count", count, SAT ? 9 : 0);
      chk("all_up_wrap", wrap, 1);
      cyc(1);
      chk("all_up_wrap_pulse", wrap, 0);

      // EVEN mode up from a loaded odd value
      load = 1'b1; load_val = 4'd3;
      cyc(1);
      load = 1'b0; even = 1'b1;
      chk("load3", count, 3);
      wait_step("even_a"); chk("even_a", count, 4);
      wait_step("even_b"); chk("even_b", count, 6);
      wait_step("even_c"); chk("even_c", count, 8);
      chk("even_c_wrap", wrap, 0);
      wait_step("even_d"); chk("even_d", count, SAT ? 8 : 0);
      chk("even_d_wrap", wrap, 1);

`ifndef MODE_COUNTER_SATURATE_EN
      // ODD mode down from 0
      load = 1'b1; load_val = 4'd0; even = 1'b0; odd = 1'b1; up = 1'b0;
      cyc(1);
      load = 1'b0;
      chk("odd_load0", count, 0);
      exp_c = '{9, 7, 5, 3, 1, 9};
      exp_w = '{1, 0, 0, 0, 0, 1};
      for (int i = 0; i < 6; i++) begin
         wait_step("odd_dn");
         chk("odd_dn_count", count, exp_c[i]);
         chk("odd_dn_wrap", wrap, exp_w[i]);
      end
`else
      // Saturation at both ends in ALL mode
      load = 1'b1; load_val = 4'd7; even = 1'b0; odd = 1'b0; up = 1'b1;
      cyc(1);
      load = 1'b0;
      exp_c = '{8, 9, 9, 9, 0, 0};
      exp_w = '{0, 0, 1, 1, 1, 1};
      for (int i = 0; i < 6; i++) begin
         if (i == 4) begin
            load = 1'b1; load_val = 4'd0; up = 1'b0;
            cyc(1);
            load = 1'b0;
         end
         wait_step("sat");
         chk("sat_count", count, exp_c[i]);
         chk("sat_wrap", wrap, exp_w[i]);
      end
`endif

      // hold freezes count while the prescaler keeps ticking
      hold = 1'b1;
      nticks = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(1);
         if (tick) nticks++;
      end
      chk("hold_ticks", nticks, 3);
      chk("hold_count", count, SAT ? 0 : 9);
      load = 1'b1; load_val = 4'd12;
      cyc(1);
      load = 1'b0;
      chk("load_clamp", count, 9);
      hold = 1'b0;

      // asynchronous reset mid-count
      even = 1'b0; odd = 1'b0; up = 1'b1;
      load = 1'b1; load_val = 4'd5;
      cyc(1);
      load = 1'b0;
      wait_step("pre_rst");
      chk("pre_rst_count", count, 6);
      reset_n = 1'b0;
      #1;
      chk("async_rst_count", count, 0);
      chk("async_rst_tick", tick, 0);
      cyc(1);
      reset_n = 1'b1;
      cyc(3);
      chk("post_rst_early", count, 0);
      chk("post_rst_tick_early", tick, 0);
      cyc(1);
      chk("post_rst_step", count, 1);
      chk("post_rst_tick", tick, 1);

      // randomized operation
      for (int i = 0; i < 2000; i++) begin
         en = ($urandom_range(0, 7) != 0);
         hold = ($urandom_range(0, 5) == 0);
         load = ($urandom_range(0, 9) == 0);
         load_val = W'($urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0) begin
            up = $urandom_range(0, 1);
            even = $urandom_range(0, 1);
            odd = $urandom_range(0, 1);
         end
         reset_n = ($urandom_range(0, 199) != 0);
         cyc(1);
      end
      reset_n = 1'b1;
      cyc(2);
      chk_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

endmodule
